// File: rtl/note_disp_pkg.sv
// Shared note codes, 7-segment patterns and the stored-digit layout for the
// multiplexed note display.
package note_disp_pkg;

  localparam logic [2:0] NOTE_C    = 3'b000;
  localparam logic [2:0] NOTE_D    = 3'b001;
  localparam logic [2:0] NOTE_E    = 3'b010;
  localparam logic [2:0] NOTE_F    = 3'b011;
  localparam logic [2:0] NOTE_G    = 3'b100;
  localparam logic [2:0] NOTE_A    = 3'b101;
  localparam logic [2:0] NOTE_B    = 3'b110;
  localparam logic [2:0] NOTE_REST = 3'b111;

  // Segment order {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_G     = 7'b1011110;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_REST  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef struct packed {
    logic       tom;
    logic [2:0] nota;
  } note_t;

endpackage

// File: rtl/note_seg_decode.sv
// Combinational note-to-segment decoder; the octave bit lights the decimal point.
module note_seg_decode
  import note_disp_pkg::*;
(
  input  note_t      note_i,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    dp_o  = note_i.tom;
    case (note_i.nota)
      NOTE_C:    seg_o = SEG_C;
      NOTE_D:    seg_o = SEG_D;
      NOTE_E:    seg_o = SEG_E;
      NOTE_F:    seg_o = SEG_F;
      NOTE_G:    seg_o = SEG_G;
      NOTE_A:    seg_o = SEG_A;
      NOTE_B:    seg_o = SEG_B;
      NOTE_REST: seg_o = SEG_REST;
    endcase
  end

endmodule

// File: rtl/note_scan_display.sv
// Note shift register feeding a time-multiplexed 7-segment scanner with a
// blanking guard at the start of each digit slot.
module note_scan_display
  import note_disp_pkg::*;
#(
  parameter  int N_DIGITS = 4,
  parameter  int SCAN_DIV = 1000,
  parameter  int GUARD    = 1,
  localparam int CNT_W    = $clog2(N_DIGITS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                tom,
  input  logic [2:0]          nota,
  input  logic                clr,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] dig_en,
  output logic [CNT_W-1:0]    count
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(N_DIGITS);

  note_t [N_DIGITS-1:0] note_q, note_d;
  logic  [N_DIGITS-1:0] vld_q, vld_d;
  logic  [CNT_W-1:0]    cnt_q, cnt_d;
  logic  [PW-1:0]       presc_q, presc_d;
  logic  [IW-1:0]       idx_q, idx_d;
  logic  [6:0]          seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic  [N_DIGITS-1:0] dig_en_q, dig_en_d;

  logic       xfer;
  logic [6:0] dec_seg;
  logic       dec_dp;

  assign in_ready = ~clr;
  assign xfer     = in_valid & in_ready;

  note_seg_decode u_dec (
    .note_i (note_q[idx_q]),
    .seg_o  (dec_seg),
    .dp_o   (dec_dp)
  );

  // Storage: newest note enters at digit 0, oldest falls off the top.
  always_comb begin
    note_d = note_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (clr) begin
      vld_d = '0;
      cnt_d = '0;
    end else if (xfer) begin
      note_d = {note_q[N_DIGITS-2:0], note_t'({tom, nota})};
      vld_d  = {vld_q[N_DIGITS-2:0], 1'b1};
      if (cnt_q != CNT_W'(N_DIGITS)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Scan timing is free-running and independent of loads/clears.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_comb begin
    dig_en_d = '1;
    if (presc_q >= PW'(GUARD)) dig_en_d[idx_q] = 1'b0;
    seg_d = vld_q[idx_q] ? dec_seg : SEG_BLANK;
    dp_d  = vld_q[idx_q] & dec_dp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_q   <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b0;
      dig_en_q <= '1;
    end else begin
      note_q   <= note_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign seg    = seg_q;
  assign dp     = dp_q;
  assign dig_en = dig_en_q;
  assign count  = cnt_q;

endmodule

// File: tb/tb_note_scan_display.sv
module tb_note_scan_display;

  logic       clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, tom = 1'b0, clr = 1'b0;
  logic [2:0] nota = 3'b000;
  logic       in_ready, dp;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic [2:0] count;

  note_scan_display #(.N_DIGITS(4), .SCAN_DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .tom(tom), .nota(nota), .clr(clr), .seg(seg), .dp(dp),
    .dig_en(dig_en), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         sig;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0, n_err = 0;
  logic [6:0] exp_seg[4];
  logic       exp_dp[4];

  function automatic logic [7:0] sample(int sig);
    case (sig)
      0:       return {1'b0, seg};
      1:       return {7'b0, dp};
      2:       return {4'b0, dig_en};
      3:       return {5'b0, count};
      default: return {7'b0, in_ready};
    endcase
  endfunction

  task automatic expect_at(int c, int sig, logic [7:0] v, string nm);
    exp_t e;
    e.cyc = c; e.sig = sig; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  function automatic logic [3:0] exp_dig(int k);
    logic [3:0] r;
    int p, d;
    p = (k - 1) % 4;
    d = ((k - 1) / 4) % 4;
    r = 4'hF;
    if (p != 0) r[d] = 1'b0;
    return r;
  endfunction

  task automatic push_scan(int a, int b);
    for (int k = a; k <= b; k++) begin
      int d;
      d = ((k - 1) / 4) % 4;
      expect_at(k, 2, {4'b0, exp_dig(k)}, "dig_en");
      expect_at(k, 0, {1'b0, exp_seg[d]}, "seg");
      expect_at(k, 1, {7'b0, exp_dp[d]}, "dp");
    end
  endtask

  task automatic push_reset();
    expect_at(0, 0, 8'h00, "rst_seg");
    expect_at(0, 1, 8'h00, "rst_dp");
    expect_at(0, 2, 8'h0F, "rst_dig_en");
    expect_at(0, 3, 8'h00, "rst_count");
    expect_at(0, 4, 8'h01, "rst_in_ready");
  endtask

  task automatic blank_all();
    for (int d = 0; d < 4; d++) begin
      exp_seg[d] = 7'b0000000;
      exp_dp[d]  = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic goto(int c);
    for (int i = 0; i < 200 && cyc < c; i++) step();
  endtask

  task automatic send(logic t, logic [2:0] n, string nm);
    in_valid = 1'b1; tom = t; nota = n;
    expect_at(cyc, 4, 8'h01, nm);
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] a;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      a = sample(e.sig);
      n_vec++;
      if (e.cyc != cyc || a !== e.val) begin
        n_err++;
        $display("FAIL %s cyc %0d (due %0d): got %0h expected %0h",
                 e.name, cyc, e.cyc, a, e.val);
      end
    end
  end

  initial begin
    #3 rst_n = 1'b0;
    push_reset();
    #1;
    n_vec++;
    if (seg !== 7'b0000000) begin n_err++; $display("FAIL direct rst seg %b", seg); end
    n_vec++;
    if (dp !== 1'b0) begin n_err++; $display("FAIL direct rst dp %b", dp); end
    n_vec++;
    if (dig_en !== 4'hF) begin n_err++; $display("FAIL direct rst dig_en %b", dig_en); end
    n_vec++;
    if (count !== 3'd0) begin n_err++; $display("FAIL direct rst count %0d", count); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL direct rst in_ready %b", in_ready); end
    repeat (3) step();
    rst_n = 1'b1;

    blank_all();
    push_scan(1, 20);
    expect_at(20, 3, 8'h00, "count_idle");

    goto(20);
    send(1'b0, 3'b000, "in_ready_c");
    step();
    in_valid = 1'b0;
    expect_at(21, 3, 8'h01, "count_one");
    exp_seg[0] = 7'b1001110;
    push_scan(22, 36);

    goto(36);
    send(1'b0, 3'b000, "in_ready_c2");
    step(); send(1'b0, 3'b001, "in_ready_d");
    step(); send(1'b0, 3'b010, "in_ready_e");
    expect_at(38, 3, 8'h03, "count_three");
    step(); send(1'b0, 3'b011, "in_ready_f");
    step(); send(1'b1, 3'b111, "in_ready_rest");
    step();
    in_valid = 1'b0;
    expect_at(41, 3, 8'h04, "count_sat");
    exp_seg[0] = 7'b0000001; exp_dp[0] = 1'b1;
    exp_seg[1] = 7'b1000111; exp_dp[1] = 1'b0;
    exp_seg[2] = 7'b1001111; exp_dp[2] = 1'b0;
    exp_seg[3] = 7'b0111101; exp_dp[3] = 1'b0;
    push_scan(42, 57);

    goto(58);
    clr = 1'b1; in_valid = 1'b1; tom = 1'b0; nota = 3'b100;
    expect_at(58, 4, 8'h00, "in_ready_clr");
    step();
    clr = 1'b0; in_valid = 1'b0;
    expect_at(59, 3, 8'h00, "count_clr");
    blank_all();
    push_scan(60, 73);
    expect_at(73, 3, 8'h00, "count_clr_hold");

    goto(73);
    in_valid = 1'b1; tom = 1'b1; nota = 3'b101;
    step();
    rst_n = 1'b0;
    #1;
    push_reset();
    n_vec++;
    if (seg !== 7'b0000000) begin n_err++; $display("FAIL direct arst seg %b", seg); end
    n_vec++;
    if (dp !== 1'b0) begin n_err++; $display("FAIL direct arst dp %b", dp); end
    n_vec++;
    if (dig_en !== 4'hF) begin n_err++; $display("FAIL direct arst dig_en %b", dig_en); end
    n_vec++;
    if (count !== 3'd0) begin n_err++; $display("FAIL direct arst count %0d", count); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL direct arst in_ready %b", in_ready); end
    repeat (3) step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    blank_all();
    push_scan(1, 8);
    expect_at(8, 3, 8'h00, "count_post_rst");

    for (int i = 0; i < 40 && sb.size() > 0; i++) step();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: got none expected %0h at cyc %0d", e.name, e.val, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
